// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - Shared widths, encodings and the ID/EX record for the decode stage
package decode_pkg;

    localparam int XLEN           = 32;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int PC_SEL_WIDTH   = 2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_FOUR = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BR   = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL  = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_SLL   = 4'd2;
    localparam logic [3:0] ALU_OP_SLT   = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd4;
    localparam logic [3:0] ALU_OP_XOR   = 4'd5;
    localparam logic [3:0] ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] ALU_OP_OR    = 4'd8;
    localparam logic [3:0] ALU_OP_AND   = 4'd9;
    localparam logic [3:0] ALU_OP_LUI   = 4'd10;
    localparam logic [3:0] ALU_OP_AUIPC = 4'd11;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [XLEN-1:0]           rs1_data;
        logic [XLEN-1:0]           rs2_data;
        logic [XLEN-1:0]           imm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [2:0]                funct3;
        logic [3:0]                alu_op;
        logic                      alu_src;
        logic                      regwrite;
        logic                      memread;
        logic                      memwrite;
        logic [1:0]                wb_sel;
    } idex_t;

    // SUB only exists in the register form; SRA/SRAI share bit 30 in both forms.
    function automatic logic [3:0] alu_op_from(input logic [2:0] funct3,
                                               input logic       bit30,
                                               input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && bit30) ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return bit30 ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry register file, two read ports with write-through bypass
module regfile
    import decode_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [XLEN-1:0]           rs1_data,
    output logic [XLEN-1:0]           rs2_data,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != '0) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (wb_en && wb_rd == rs1_addr) ? wb_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (wb_en && wb_rd == rs2_addr) ? wb_data : regs_q[rs2_addr];
        end
    end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: control, immediates, branch resolve, hazards, ID/EX
module decode
    import decode_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [XLEN-1:0]           pc_decode,
    input  logic [XLEN-1:0]           instr_decode,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [XLEN-1:0]           alu_mem,
    input  logic [REG_ADDR_WIDTH-1:0] rd_mem,
    input  logic                      regwrite_mem,
    input  logic                      memread_mem,
    output logic [PC_SEL_WIDTH-1:0]   pc_sel,
    output logic [XLEN-1:0]           br_decode,
    output logic [XLEN-1:0]           jal_decode,
    output logic [XLEN-1:0]           jalr_decode,
    output logic                      stall_if,
    output logic                      flush_if,
    output logic [XLEN-1:0]           pc_ex,
    output logic [XLEN-1:0]           rs1_data_ex,
    output logic [XLEN-1:0]           rs2_data_ex,
    output logic [XLEN-1:0]           imm_ex,
    output logic [REG_ADDR_WIDTH-1:0] rs1_ex,
    output logic [REG_ADDR_WIDTH-1:0] rs2_ex,
    output logic [REG_ADDR_WIDTH-1:0] rd_ex,
    output logic [2:0]                funct3_ex,
    output logic [3:0]                alu_op_ex,
    output logic                      alu_src_ex,
    output logic                      regwrite_ex,
    output logic                      memread_ex,
    output logic                      memwrite_ex,
    output logic [1:0]                wb_sel_ex
);

    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic [2:0]                funct3;
    logic [XLEN-1:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]           rf_rs1, rf_rs2, op1, op2, jalr_sum;
    logic                      uses_rs1, uses_rs2, is_jal, is_jalr, is_branch;
    logic                      taken, stall, hit_ex, hit_mem;
    idex_t                     dec, idex_d, idex_q;

    assign opcode = instr_decode[6:0];
    assign rd     = instr_decode[11:7];
    assign funct3 = instr_decode[14:12];
    assign rs1    = instr_decode[19:15];
    assign rs2    = instr_decode[24:20];

    assign imm_i = {{20{instr_decode[31]}}, instr_decode[31:20]};
    assign imm_s = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
    assign imm_b = {{19{instr_decode[31]}}, instr_decode[31], instr_decode[7],
                    instr_decode[30:25], instr_decode[11:8], 1'b0};
    assign imm_u = {instr_decode[31:12], 12'b0};
    assign imm_j = {{11{instr_decode[31]}}, instr_decode[31], instr_decode[19:12],
                    instr_decode[20], instr_decode[30:21], 1'b0};

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    always_comb begin
        dec          = '0;
        dec.pc       = pc_decode;
        dec.rs1_data = rf_rs1;
        dec.rs2_data = rf_rs2;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.funct3   = funct3;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        is_jal       = 1'b0;
        is_jalr      = 1'b0;
        is_branch    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.imm = imm_u; dec.alu_op = ALU_OP_LUI; dec.alu_src = 1'b1; dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u; dec.alu_op = ALU_OP_AUIPC; dec.alu_src = 1'b1; dec.regwrite = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1; dec.imm = imm_j; dec.wb_sel = WB_SEL_PC4; dec.regwrite = (rd != '0);
            end
            OPC_JALR: begin
                is_jalr = 1'b1; uses_rs1 = 1'b1; dec.imm = imm_i;
                dec.wb_sel = WB_SEL_PC4; dec.regwrite = (rd != '0);
            end
            OPC_BRANCH: begin
                is_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.imm = imm_b;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1; dec.imm = imm_i; dec.alu_src = 1'b1;
                dec.regwrite = 1'b1; dec.memread = 1'b1; dec.wb_sel = WB_SEL_MEM;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.imm = imm_s; dec.alu_src = 1'b1; dec.memwrite = 1'b1;
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1; dec.imm = imm_i; dec.alu_src = 1'b1; dec.regwrite = 1'b1;
                dec.alu_op = alu_op_from(funct3, instr_decode[30], 1'b0);
            end
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.regwrite = 1'b1;
                dec.alu_op = alu_op_from(funct3, instr_decode[30], 1'b1);
            end
            default: ;
        endcase
    end

    // A load in MEM has no value yet, so it is never a forwarding source.
    assign op1 = (regwrite_mem && !memread_mem && rd_mem != '0 && rd_mem == rs1) ? alu_mem : rf_rs1;
    assign op2 = (regwrite_mem && !memread_mem && rd_mem != '0 && rd_mem == rs2) ? alu_mem : rf_rs2;

    always_comb begin
        case (funct3)
            3'b000:  taken = (op1 == op2);
            3'b001:  taken = (op1 != op2);
            3'b100:  taken = ($signed(op1) <  $signed(op2));
            3'b101:  taken = ($signed(op1) >= $signed(op2));
            3'b110:  taken = (op1 <  op2);
            3'b111:  taken = (op1 >= op2);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum    = op1 + imm_i;
    assign br_decode   = pc_decode + imm_b;
    assign jal_decode  = pc_decode + imm_j;
    assign jalr_decode = {jalr_sum[XLEN-1:1], 1'b0};

    assign hit_ex  = idex_q.rd != '0 && ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
    assign hit_mem = rd_mem != '0 && ((uses_rs1 && rd_mem == rs1) || (uses_rs2 && rd_mem == rs2));
    assign stall   = rst_n && ((idex_q.memread && hit_ex) ||
                               ((is_branch || is_jalr) && ((idex_q.regwrite && hit_ex) ||
                                                           (memread_mem && hit_mem))));

    always_comb begin
        pc_sel = PC_SEL_FOUR;
        if (rst_n && !stall) begin
            if (is_jal)                  pc_sel = PC_SEL_JAL;
            else if (is_jalr)            pc_sel = PC_SEL_JALR;
            else if (is_branch && taken) pc_sel = PC_SEL_BR;
        end
    end

    assign flush_if = (pc_sel != PC_SEL_FOUR);
    assign stall_if = stall;

    always_comb begin
        idex_d = dec;
        if (stall) begin
            idex_d.alu_op   = '0;
            idex_d.alu_src  = 1'b0;
            idex_d.regwrite = 1'b0;
            idex_d.memread  = 1'b0;
            idex_d.memwrite = 1'b0;
            idex_d.wb_sel   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign pc_ex       = idex_q.pc;
    assign rs1_data_ex = idex_q.rs1_data;
    assign rs2_data_ex = idex_q.rs2_data;
    assign imm_ex      = idex_q.imm;
    assign rs1_ex      = idex_q.rs1;
    assign rs2_ex      = idex_q.rs2;
    assign rd_ex       = idex_q.rd;
    assign funct3_ex   = idex_q.funct3;
    assign alu_op_ex   = idex_q.alu_op;
    assign alu_src_ex  = idex_q.alu_src;
    assign regwrite_ex = idex_q.regwrite;
    assign memread_ex  = idex_q.memread;
    assign memwrite_ex = idex_q.memwrite;
    assign wb_sel_ex   = idex_q.wb_sel;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - Directed self-checking bench for the decode stage
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_decode = '0, instr_decode = '0, wb_data = '0, alu_mem = '0;
    logic [4:0]  wb_rd = '0, rd_mem = '0;
    logic        wb_en = 1'b0, regwrite_mem = 1'b0, memread_mem = 1'b0;
    logic [1:0]  pc_sel, wb_sel_ex;
    logic [31:0] br_decode, jal_decode, jalr_decode;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [2:0]  funct3_ex;
    logic [3:0]  alu_op_ex;
    logic        stall_if, flush_if, alu_src_ex, regwrite_ex, memread_ex, memwrite_ex;
    int          errors = 0, checks = 0;

    decode dut (
        .clk(clk), .rst_n(rst_n), .pc_decode(pc_decode), .instr_decode(instr_decode),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .alu_mem(alu_mem),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .memread_mem(memread_mem),
        .pc_sel(pc_sel), .br_decode(br_decode), .jal_decode(jal_decode),
        .jalr_decode(jalr_decode), .stall_if(stall_if), .flush_if(flush_if),
        .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .funct3_ex(funct3_ex), .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .wb_sel_ex(wb_sel_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), OPC_JAL};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int r, input logic [31:0] v);
        instr_decode = '0;
        wb_en = 1'b1; wb_rd = 5'(r); wb_data = v;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_decode = 32'h40; instr_decode = enc_j(8, 1);
        step(); step();
        checks++; if (pc_sel !== PC_SEL_FOUR) begin errors++; $display("FAIL reset_pc_sel: got %0d want %0d", pc_sel, PC_SEL_FOUR); end
        checks++; if ({stall_if, flush_if} !== 2'b00) begin errors++; $display("FAIL reset_stall_flush: got %b want 00", {stall_if, flush_if}); end
        checks++; if ({pc_ex, imm_ex, rd_ex, regwrite_ex, wb_sel_ex, alu_op_ex} !== '0) begin
            errors++; $display("FAIL reset_idex: got pc=%h imm=%h rd=%0d rw=%b wb=%0d op=%0d want all 0",
                               pc_ex, imm_ex, rd_ex, regwrite_ex, wb_sel_ex, alu_op_ex); end
        rst_n = 1'b1; instr_decode = '0;
        step();
    endtask

    task automatic test_addi();
        write_reg(5, 32'd7);
        pc_decode = 32'h10; instr_decode = enc_i(3, 5, 0, 6, OPC_OP_IMM);
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL addi_stall: got %b want 0", stall_if); end
        step();
        checks++; if (rs1_data_ex !== 32'd7) begin errors++; $display("FAIL addi_rs1_data: got %h want 7", rs1_data_ex); end
        checks++; if (imm_ex !== 32'd3) begin errors++; $display("FAIL addi_imm: got %h want 3", imm_ex); end
        checks++; if ({rd_ex, regwrite_ex, alu_src_ex} !== {5'd6, 1'b1, 1'b1}) begin
            errors++; $display("FAIL addi_ctrl: got rd=%0d rw=%b src=%b want rd=6 rw=1 src=1", rd_ex, regwrite_ex, alu_src_ex); end
        checks++; if (pc_ex !== 32'h10) begin errors++; $display("FAIL addi_pc_ex: got %h want 10", pc_ex); end
    endtask

    task automatic test_branches();
        write_reg(1, 32'd9);
        write_reg(2, 32'd9);
        pc_decode = 32'h20; instr_decode = enc_b(16, 2, 1, 0);
        #1;
        checks++; if ({pc_sel, flush_if} !== {PC_SEL_BR, 1'b1}) begin errors++; $display("FAIL beq_taken: got sel=%0d flush=%b want sel=1 flush=1", pc_sel, flush_if); end
        checks++; if (br_decode !== 32'h30) begin errors++; $display("FAIL beq_target: got %h want 30", br_decode); end
        instr_decode = enc_b(16, 2, 1, 1);
        #1;
        checks++; if ({pc_sel, flush_if} !== {PC_SEL_FOUR, 1'b0}) begin errors++; $display("FAIL bne_not_taken: got sel=%0d flush=%b want sel=0 flush=0", pc_sel, flush_if); end
        instr_decode = enc_b(16, 2, 1, 0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        #1;
        checks++; if (pc_sel !== PC_SEL_FOUR) begin errors++; $display("FAIL wb_bypass_beq: got sel=%0d want 0", pc_sel); end
        step();
        wb_en = 1'b0;
        write_reg(9, 32'hFFFF_FFFF);
        pc_decode = 32'h100; instr_decode = enc_b(-8, 0, 9, 4);
        #1;
        checks++; if ({pc_sel, br_decode} !== {PC_SEL_BR, 32'hF8}) begin errors++; $display("FAIL blt_neg: got sel=%0d tgt=%h want sel=1 tgt=f8", pc_sel, br_decode); end
        instr_decode = enc_b(-8, 0, 9, 6);
        #1;
        checks++; if (pc_sel !== PC_SEL_FOUR) begin errors++; $display("FAIL bltu_not_taken: got sel=%0d want 0", pc_sel); end
        instr_decode = enc_b(-8, 0, 9, 7);
        #1;
        checks++; if (pc_sel !== PC_SEL_BR) begin errors++; $display("FAIL bgeu_taken: got sel=%0d want 1", pc_sel); end
    endtask

    task automatic test_load_use();
        pc_decode = 32'h40; instr_decode = enc_i(0, 10, 2, 3, OPC_LOAD);
        step();
        pc_decode = 32'h44; instr_decode = enc_r(0, 1, 3, 0, 4);
        #1;
        checks++; if ({stall_if, flush_if} !== 2'b10) begin errors++; $display("FAIL load_use_stall: got stall=%b flush=%b want 1 0", stall_if, flush_if); end
        step();
        checks++; if ({regwrite_ex, memread_ex, memwrite_ex, wb_sel_ex, alu_op_ex, alu_src_ex} !== '0) begin
            errors++; $display("FAIL load_use_bubble: got rw=%b mr=%b mw=%b wb=%0d op=%0d want all 0",
                               regwrite_ex, memread_ex, memwrite_ex, wb_sel_ex, alu_op_ex); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", stall_if); end
        step();
        checks++; if ({rd_ex, regwrite_ex} !== {5'd4, 1'b1}) begin errors++; $display("FAIL load_use_add: got rd=%0d rw=%b want 4 1", rd_ex, regwrite_ex); end
        instr_decode = enc_i(0, 10, 2, 3, OPC_LOAD);
        step();
        instr_decode = 32'h0001_82B7;
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL lui_no_rs_stall: got %b want 0", stall_if); end
        step();
    endtask

    task automatic test_branch_hazards();
        pc_decode = 32'h80; instr_decode = enc_i(1, 0, 0, 8, OPC_OP_IMM);
        step();
        pc_decode = 32'h84; instr_decode = enc_b(12, 0, 8, 1);
        #1;
        checks++; if ({stall_if, pc_sel} !== {1'b1, PC_SEL_FOUR}) begin errors++; $display("FAIL br_ex_stall: got stall=%b sel=%0d want 1 0", stall_if, pc_sel); end
        step();
        regwrite_mem = 1'b1; rd_mem = 5'd8; alu_mem = 32'd1;
        #1;
        checks++; if ({stall_if, pc_sel, br_decode} !== {1'b0, PC_SEL_BR, 32'h90}) begin
            errors++; $display("FAIL br_ex_fwd: got stall=%b sel=%0d tgt=%h want 0 1 90", stall_if, pc_sel, br_decode); end
        pc_decode = 32'h88; instr_decode = enc_i(0, 0, 2, 12, OPC_LOAD);
        regwrite_mem = 1'b0; rd_mem = '0; alu_mem = '0;
        step();
        pc_decode = 32'h8C; instr_decode = enc_b(8, 0, 12, 0);
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL br_load_stall1: got %b want 1", stall_if); end
        step();
        regwrite_mem = 1'b1; memread_mem = 1'b1; rd_mem = 5'd12;
        #1;
        checks++; if ({stall_if, flush_if} !== 2'b10) begin errors++; $display("FAIL br_load_stall2: got stall=%b flush=%b want 1 0", stall_if, flush_if); end
        step();
        regwrite_mem = 1'b0; memread_mem = 1'b0; rd_mem = '0;
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL br_load_release: got %b want 0", stall_if); end
    endtask

    task automatic test_jumps();
        write_reg(7, 32'h101);
        pc_decode = 32'h50; instr_decode = enc_i(4, 7, 0, 1, OPC_JALR);
        #1;
        checks++; if ({pc_sel, flush_if} !== {PC_SEL_JALR, 1'b1}) begin errors++; $display("FAIL jalr_sel: got sel=%0d flush=%b want 3 1", pc_sel, flush_if); end
        checks++; if (jalr_decode !== 32'h104) begin errors++; $display("FAIL jalr_target: got %h want 104", jalr_decode); end
        step();
        checks++; if ({wb_sel_ex, regwrite_ex, pc_ex} !== {WB_SEL_PC4, 1'b1, 32'h50}) begin
            errors++; $display("FAIL jalr_idex: got wb=%0d rw=%b pc=%h want 2 1 50", wb_sel_ex, regwrite_ex, pc_ex); end
        pc_decode = 32'h60; instr_decode = enc_j(-16, 0);
        #1;
        checks++; if ({pc_sel, jal_decode} !== {PC_SEL_JAL, 32'h50}) begin errors++; $display("FAIL jal_sel: got sel=%0d tgt=%h want 2 50", pc_sel, jal_decode); end
        step();
        checks++; if ({wb_sel_ex, regwrite_ex} !== {WB_SEL_PC4, 1'b0}) begin errors++; $display("FAIL jal_x0_idex: got wb=%0d rw=%b want 2 0", wb_sel_ex, regwrite_ex); end
    endtask

    task automatic test_forwarding();
        instr_decode = '0;
        step();
        regwrite_mem = 1'b1; rd_mem = 5'd2; alu_mem = 32'd5;
        pc_decode = 32'h70; instr_decode = enc_b(8, 0, 2, 0);
        #1;
        checks++; if (pc_sel !== PC_SEL_FOUR) begin errors++; $display("FAIL fwd_not_taken: got sel=%0d want 0", pc_sel); end
        alu_mem = 32'd0;
        #1;
        checks++; if ({pc_sel, br_decode} !== {PC_SEL_BR, 32'h78}) begin errors++; $display("FAIL fwd_taken: got sel=%0d tgt=%h want 1 78", pc_sel, br_decode); end
        memread_mem = 1'b1;
        #1;
        checks++; if ({stall_if, pc_sel, flush_if} !== {1'b1, PC_SEL_FOUR, 1'b0}) begin
            errors++; $display("FAIL stall_over_redirect: got stall=%b sel=%0d flush=%b want 1 0 0", stall_if, pc_sel, flush_if); end
        regwrite_mem = 1'b0; memread_mem = 1'b0; rd_mem = '0;
        step();
    endtask

    task automatic test_store_and_x0();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        instr_decode = enc_r(0, 0, 0, 0, 11);
        step();
        wb_en = 1'b0;
        checks++; if ({rs1_data_ex, rs2_data_ex} !== 64'd0) begin errors++; $display("FAIL x0_read: got %h %h want 0 0", rs1_data_ex, rs2_data_ex); end
        pc_decode = 32'hA0; instr_decode = enc_s(-4, 2, 1, 2);
        step();
        checks++; if ({imm_ex, memwrite_ex, regwrite_ex, rs2_data_ex} !== {32'hFFFF_FFFC, 1'b1, 1'b0, 32'd9}) begin
            errors++; $display("FAIL store_idex: got imm=%h mw=%b rw=%b rs2=%h want fffffffc 1 0 9", imm_ex, memwrite_ex, regwrite_ex, rs2_data_ex); end
    endtask

    task automatic test_reset_mid_stall();
        instr_decode = enc_i(0, 10, 2, 3, OPC_LOAD);
        step();
        instr_decode = enc_r(0, 1, 3, 0, 4);
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b want 1", stall_if); end
        rst_n = 1'b0;
        #1;
        checks++; if ({stall_if, flush_if, pc_sel} !== {1'b0, 1'b0, PC_SEL_FOUR}) begin
            errors++; $display("FAIL reset_drops_stall: got stall=%b flush=%b sel=%0d want 0 0 0", stall_if, flush_if, pc_sel); end
        step();
        checks++; if ({memread_ex, rd_ex, pc_ex} !== '0) begin errors++; $display("FAIL reset_clears_idex: got mr=%b rd=%0d pc=%h want 0", memread_ex, rd_ex, pc_ex); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branches();
        test_load_use();
        test_branch_hazards();
        test_jumps();
        test_forwarding();
        test_store_and_x0();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the five-stage RV32I pipeline. It consumes the IF/ID register produced by `fetch`, reads the register file, and generates immediates and control. Branches and jumps are resolved here: `decode` drives `pc_sel`, the three redirect targets and `stall_if`/`flush_if` back to `fetch`. It registers everything into the ID/EX pipeline register for the execute stage.

## Interface
- Parameters: none; widths come from `constants.vh` (`XLEN`=32, `REG_DATA_WIDTH`=32, `PC_SEL_WIDTH`, `REG_ADDR_WIDTH`=5).
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pc_decode` in XLEN: PC of the instruction in IF/ID.
- `instr_decode` in XLEN: instruction in IF/ID.
- `wb_en` in 1: writeback write enable.
- `wb_rd` in 5: writeback destination register.
- `wb_data` in XLEN: writeback data.
- `alu_mem` in XLEN: EX/MEM ALU result, forwarded to the branch comparator.
- `rd_mem` in 5: EX/MEM destination register.
- `regwrite_mem` in 1: EX/MEM write flag.
- `memread_mem` in 1: EX/MEM load flag.
- `pc_sel` out PC_SEL_WIDTH: `PC_SEL_FOUR`/`PC_SEL_BR`/`PC_SEL_JAL`/`PC_SEL_JALR`.
- `br_decode` out XLEN: branch target.
- `jal_decode` out XLEN: JAL target.
- `jalr_decode` out XLEN: JALR target.
- `stall_if` out 1: hold PC and IF/ID.
- `flush_if` out 1: squash IF/ID.
- ID/EX register outputs (all out):
  - `pc_ex` XLEN
  - `rs1_data_ex` XLEN
  - `rs2_data_ex` XLEN
  - `imm_ex` XLEN
  - `rs1_ex` 5
  - `rs2_ex` 5
  - `rd_ex` 5
  - `funct3_ex` 3
  - `alu_op_ex` 4
  - `alu_src_ex` 1
  - `regwrite_ex` 1
  - `memread_ex` 1
  - `memwrite_ex` 1
  - `wb_sel_ex` 2

## Operation
- **Decode:** full RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode, including 0x00000000, decodes as a bubble: all control bits 0 and no redirect.
- **Immediates:** I/S/B/U/J formats, sign-extended to XLEN. Target arithmetic is modulo 2^32.
  - `br_decode` = pc + B-imm.
  - `jal_decode` = pc + J-imm.
  - `jalr_decode` = (op1 + I-imm) & ~1.
- **Register file** (sub-module `regfile`):
  - 32×XLEN storage, two combinational read ports, one write port on the rising edge.
  - x0 always reads 0, and writes to x0 are ignored.
  - Write-through bypass: a read of `wb_rd` while `wb_en` is asserted returns `wb_data` in the same cycle.
- **Comparator operands** `op1`/`op2`:
  - Forward `alu_mem` when `regwrite_mem && !memread_mem && rd_mem!=0 && rd_mem==rs`.
  - Otherwise use the regfile read, including its bypass.
- **Branch compare:** BEQ, BNE, BLT, BGE, BLTU, BGEU, selected by funct3.
- **Hazard detect** (combinational). `stall` = any of:
  - (a) `memread_ex && rd_ex!=0` and `rd_ex` matches a used rs1/rs2 (load-use);
  - (b) current instruction is BRANCH/JALR, `regwrite_ex && rd_ex!=0`, and `rd_ex` matches a used rs;
  - (c) current instruction is BRANCH/JALR, `memread_mem && rd_mem!=0`, and `rd_mem` matches a used rs.
  - Only registers the format actually reads count as "used": JAL, LUI and AUIPC read none.
- **Redirect:**
  - When `stall`: `pc_sel`=`PC_SEL_FOUR` and `flush_if`=0.
  - Otherwise `pc_sel` = JAL / JALR / BR (taken branch only) / FOUR, and `flush_if` = (`pc_sel`!=`PC_SEL_FOUR`).
  - `stall_if` = `stall`.
- **ID/EX update**, every rising edge:
  - If `!rst_n`: all ID/EX outputs go to 0.
  - Else if `stall`: bubble. All control outputs go to 0; the data fields may update.
  - Else: load the decoded values.
- **JAL/JALR writeback:** these load `wb_sel_ex`=PC+4 and `regwrite_ex`=1 when rd!=0.

## Timing
- Redirect and hazard outputs are combinational from IF/ID, ID/EX and EX/MEM state. `fetch` samples them on the next edge.
- Decode latency is 1 cycle: IF/ID contents appear on the ID/EX outputs after the next rising edge.
- A taken branch or jump costs 1 bubble, the squashed fall-through instruction.
- A load-use hazard costs 1 stall cycle. A branch depending on an EX-stage ALU result stalls 1 cycle and then forwards from MEM. A branch depending on a load stalls 2 cycles.
- **Reset:**
  - The regfile clears to 0 and the ID/EX outputs clear to 0.
  - During reset `stall_if`=0, `flush_if`=0 and `pc_sel`=`PC_SEL_FOUR`.
  - When `rst_n` is asserted mid-stall, the stall is dropped on that edge.
- **Simultaneous events:**
  - A stall overrides a redirect, and the redirect is re-evaluated on the following cycle.
  - A writeback to the same register being read in decode is returned via the bypass.

## Structure
- `constants.vh` holds:
  - `PC_SEL_*` encodings;
  - opcode constants;
  - `ALU_OP_*` (4-bit);
  - `WB_SEL_*` (ALU=0, MEM=1, PC4=2);
  - `REG_ADDR_WIDTH`.
- Sub-module `regfile`, instantiated once: synchronous reset, write-through, x0 hardwired to 0.
- Everything else lives in `decode`: immediate generation, control decode, comparator, hazard unit and ID/EX register.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles → all `*_ex` outputs 0, `pc_sel`=`PC_SEL_FOUR`, `stall_if`=0, `flush_if`=0.
- **ADDI decode:** after x5 is written with 7 via `wb_*`, IF/ID = `addi x6,x5,3` at pc 0x10 → next cycle `rs1_data_ex`=7, `imm_ex`=3, `rd_ex`=6, `regwrite_ex`=1, no stall.
- **Taken BEQ:** x1=x2=9, `beq x1,x2,+16` at pc 0x20 → `pc_sel`=`PC_SEL_BR`, `br_decode`=0x30, `flush_if`=1.
- **Not-taken BNE:** same operands with `bne` → `pc_sel`=`PC_SEL_FOUR`, `flush_if`=0.
- **Load-use:** ID/EX holds `lw x3` and decode holds `add x4,x3,x1` → `stall_if`=1 for 1 cycle and the ID/EX control outputs are 0 that cycle. The next cycle has no stall.
- **JALR:** x7=0x101, `jalr x1,4(x7)` → `pc_sel`=`PC_SEL_JALR`, `jalr_decode`=0x104, `wb_sel_ex`=PC4.
- **Forwarding to the comparator:** `regwrite_mem`=1, `rd_mem`=2, `alu_mem`=5 with `beq x2,x0` → not taken. The same case with `alu_mem`=0 → taken.
